// File: rtl/top.sv
// DHT11 poller: periodically reads a DHT11 sensor over its open-drain single-wire
// bus and presents the last checksum-valid integral temperature and humidity.

module dht11_ctrl #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int POLL_MS  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_in,
    output logic        drive_low,
    output logic [15:0] temp_humi
);

    // Sub-cycle thresholds are clamped to a few cycles so the bus still resolves at slow clocks.
    function automatic logic [31:0] cycles_of(input logic [63:0] num, input logic [63:0] den,
                                              input logic [31:0] floor_v);
        logic [63:0] c;
        c = (64'(CLK_FREQ) * num) / den;
        if (c < {32'd0, floor_v}) begin
            return floor_v;
        end else begin
            return c[31:0];
        end
    endfunction

    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

    localparam logic [31:0] T_POWER   = cycles_of(64'd1, 64'd1, 32'd16);
    localparam logic [31:0] T_START   = cycles_of(64'd20, 64'd1000, 32'd8);
    localparam logic [31:0] T_BIT     = cycles_of(64'd40, 64'd1_000_000, 32'd4);
    localparam logic [31:0] T_TIMEOUT = cycles_of(64'd200, 64'd1_000_000, 32'd20);
    localparam logic [31:0] T_POLL    = cycles_of(64'(POLL_MS), 64'd1000, 32'd16);

    typedef enum logic [3:0] {
        POWER_UP  = 4'd0,
        START     = 4'd1,
        RELEASE   = 4'd2,
        RESP_LOW  = 4'd3,
        RESP_HIGH = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        CHECK     = 4'd7,
        IDLE      = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_nx;
    logic [1:0]  sync_r;
    logic        line_prev_r;
    logic [31:0] tmr_r;
    logic [31:0] lvl_cnt_r;
    logic [5:0]  bit_cnt_r;
    logic [39:0] shift_r;
    logic        drive_low_r;
    logic [15:0] TempHumi;

    logic        line_s;
    logic        rise_s;
    logic        fall_s;
    logic        in_frame_s;
    logic        timeout_s;
    logic        enter_start_s;
    logic        drive_low_s;

    assign line_s    = sync_r[1];
    assign rise_s    = line_s & ~line_prev_r;
    assign fall_s    = ~line_s & line_prev_r;
    assign drive_low = drive_low_r;
    assign temp_humi = TempHumi;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= POWER_UP;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; every wait on the sensor is guarded by the level timeout.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            POWER_UP: begin
                if (tmr_r >= T_POWER - 32'd1) state_nx = START;
                else                          state_nx = state_r;
            end
            START: begin
                if (tmr_r >= T_START - 32'd1) state_nx = RELEASE;
                else                          state_nx = state_r;
            end
            RELEASE: begin
                if (timeout_s)   state_nx = IDLE;
                else if (fall_s) state_nx = RESP_LOW;
                else             state_nx = state_r;
            end
            RESP_LOW: begin
                if (timeout_s)   state_nx = IDLE;
                else if (rise_s) state_nx = RESP_HIGH;
                else             state_nx = state_r;
            end
            RESP_HIGH: begin
                if (timeout_s)   state_nx = IDLE;
                else if (fall_s) state_nx = BIT_LOW;
                else             state_nx = state_r;
            end
            BIT_LOW: begin
                if (timeout_s)   state_nx = IDLE;
                else if (rise_s) state_nx = BIT_HIGH;
                else             state_nx = state_r;
            end
            BIT_HIGH: begin
                if (timeout_s)                   state_nx = IDLE;
                else if (fall_s && bit_cnt_r == 6'd39) state_nx = CHECK;
                else if (fall_s)                 state_nx = BIT_LOW;
                else                             state_nx = state_r;
            end
            CHECK: begin
                state_nx = IDLE;
            end
            IDLE: begin
                if (tmr_r >= T_POLL - 32'd1) state_nx = START;
                else                         state_nx = state_r;
            end
            default: begin
                state_nx = POWER_UP;
            end
        endcase
    end

    // Output and qualifier decode from the current state.
    always_comb begin
        drive_low_s   = 1'b0;
        in_frame_s    = 1'b0;
        enter_start_s = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            START:                                       drive_low_s = 1'b1;
            RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: in_frame_s = 1'b1;
            default: begin
                drive_low_s = 1'b0;
                in_frame_s  = 1'b0;
            end
        endcase
        if (in_frame_s && lvl_cnt_r >= T_TIMEOUT) timeout_s = 1'b1;
        else                                      timeout_s = 1'b0;
        if (state_nx == START && state_r != START) enter_start_s = 1'b1;
        else                                       enter_start_s = 1'b0;
    end

    // Line synchronizer, timers, bit capture and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= 2'b11;
            line_prev_r <= 1'b1;
            tmr_r       <= 32'd0;
            lvl_cnt_r   <= 32'd0;
            bit_cnt_r   <= 6'd0;
            shift_r     <= 40'd0;
            drive_low_r <= 1'b0;
            TempHumi    <= 16'h0000;
        end else begin
            sync_r      <= {sync_r[0], line_in};
            line_prev_r <= line_s;
            drive_low_r <= drive_low_s;

            // The poll period is measured from START entry, so the timer restarts there.
            if (enter_start_s)              tmr_r <= 32'd0;
            else if (tmr_r != 32'hFFFF_FFFF) tmr_r <= tmr_r + 32'd1;

            if (!in_frame_s || rise_s || fall_s) lvl_cnt_r <= 32'd0;
            else if (lvl_cnt_r != 32'hFFFF_FFFF) lvl_cnt_r <= lvl_cnt_r + 32'd1;

            if (enter_start_s) begin
                bit_cnt_r <= 6'd0;
                shift_r   <= 40'd0;
            end else if (state_r == BIT_HIGH && fall_s) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                shift_r   <= {shift_r[38:0], (lvl_cnt_r >= T_BIT)};
            end

            if (state_r == CHECK && checksum_ok(shift_r)) begin
                TempHumi <= {shift_r[23:16], shift_r[39:32]};
            end
        end
    end

endmodule

module top #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int POLL_MS  = 1000
) (
    input  logic       col_clk,
    input  logic       sys_rst_n,
    inout  wire        dht11,
    output logic [7:0] temp_out,
    output logic [7:0] hum_out
);

    logic        drive_low_s;
    logic [15:0] temp_humi_s;

    dht11_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .POLL_MS  (POLL_MS)
    ) dht11_inst (
        .clk       (col_clk),
        .rst_n     (sys_rst_n),
        .line_in   (dht11),
        .drive_low (drive_low_s),
        .temp_humi (temp_humi_s)
    );

    // Open-drain: only ever pull low, otherwise leave the bus to the pull-up.
    assign dht11    = drive_low_s ? 1'b0 : 1'bz;
    assign temp_out = temp_humi_s[15:8];
    assign hum_out  = temp_humi_s[7:0];

endmodule

// File: tb/tb_top.sv
// Bench for the DHT11 poller: a cycle-level sensor model answers host START pulses,
// and a scoreboard compares the published readings against a checksum-rule reference.
`timescale 1ns/1ps
module tb_top;

    // Reduced clock rate keeps 1 s power-up and poll intervals short in cycles.
    localparam int CF      = 8000;
    localparam int POLL    = 1000;
    localparam int T_POWER = CF;
    localparam int T_POLL  = CF * POLL / 1000;
    localparam int T_START = CF / 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire        dht11;
    logic [7:0] temp_out;
    logic [7:0] hum_out;
    logic       sens_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    top #(.CLK_FREQ(CF), .POLL_MS(POLL)) dut (
        .col_clk   (clk),
        .sys_rst_n (rst_n),
        .dht11     (dht11),
        .temp_out  (temp_out),
        .hum_out   (hum_out)
    );

    assign dht11 = sens_low ? 1'b0 : 1'bz;
    pullup (dht11);

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host activity watcher: the line low while the sensor is not pulling means the DUT drives it.
    wire  host_now = (dht11 === 1'b0) && !sens_low;
    logic host_q = 1'b0;
    int   start_cnt = 0;
    int   release_cnt = 0;
    int   last_start = 0;
    int   low_len = 0;
    always @(negedge clk) begin
        host_q <= host_now;
        if (host_now && !host_q) begin
            start_cnt  <= start_cnt + 1;
            last_start <= cyc;
        end
        if (!host_now && host_q) begin
            release_cnt <= release_cnt + 1;
            low_len     <= cyc - last_start;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Reference: a frame updates the reading only when its byte sum matches the checksum.
    function automatic logic [15:0] ref_model(input logic [15:0] cur, input logic [39:0] f);
        int sum;
        sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        if ((sum % 256) == int'(f[7:0])) return {f[23:16], f[39:32]};
        else                             return cur;
    endfunction

    // Sensor model: responds after each host release when enabled.
    logic        sens_on = 1'b0;
    logic [39:0] frame = 40'd0;
    int          done_cnt = 0;
    int          bit_idx = -1;
    logic        in_high = 1'b0;

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] f;
        int seen;
        forever begin
            seen = release_cnt;
            wait (release_cnt != seen);
            if (sens_on) begin
                f = frame;
                gap(3); sens_low = 1'b1; gap(8); sens_low = 1'b0; gap(8);
                for (int i = 0; i < 40; i++) begin
                    sens_low = 1'b1;
                    gap(int'($urandom_range(7, 3)));
                    sens_low = 1'b0;
                    bit_idx = i;
                    in_high = 1'b1;
                    if (f[39-i]) gap(int'($urandom_range(10, 6)));
                    else         gap(int'($urandom_range(3, 2)));
                    in_high = 1'b0;
                end
                sens_low = 1'b1; gap(4); sens_low = 1'b0;
                bit_idx = -1;
                done_cnt++;
            end
        end
    end

    // Scoreboard monitor: on each publish request, compare outputs to queued expectations.
    logic [15:0] exp_q[$];
    string       tag_q[$];
    event        chk_ev;
    initial begin
        logic [15:0] e;
        string t;
        forever begin
            @(chk_ev);
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_temp"}, int'(temp_out), int'(e[15:8]));
                check({t, "_hum"}, int'(hum_out), int'(e[7:0]));
            end
        end
    end

    logic [15:0] model_th = 16'h0000;

    task automatic expect_now(input string tag);
        exp_q.push_back(model_th);
        tag_q.push_back(tag);
        -> chk_ev;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_start(input int budget, input string name);
        int seen;
        int k;
        seen = start_cnt;
        k = 0;
        while (start_cnt == seen && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_start_seen"}, int'(start_cnt != seen), 1);
    endtask

    task automatic wait_done(input string name);
        int seen;
        int k;
        seen = done_cnt;
        k = 0;
        while (done_cnt == seen && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check({name, "_frame_done"}, int'(done_cnt != seen), 1);
        repeat (10) @(posedge clk);
    endtask

    task automatic run_frame(input logic [39:0] f, input string name, input logic wait_for_start);
        int prev_start;
        frame    = f;
        sens_on  = 1'b1;
        model_th = ref_model(model_th, f);
        if (wait_for_start) begin
            prev_start = last_start;
            wait_start(T_POLL + 100, name);
            check_range({name, "_poll_interval"}, last_start - prev_start, T_POLL - 2, T_POLL + 2);
        end
        wait_done(name);
        check_range({name, "_start_low_len"}, low_len, T_START - T_START / 100, T_START + T_START / 100);
        expect_now(name);
    endtask

    initial begin
        int t0;
        int prev_start;
        int k;
        int s0;
        logic [7:0] h, hd, t, td, cs;

        // Reset state.
        rst_n = 1'b0;
        #200;
        check("rst_temp", int'(temp_out), 0);
        check("rst_hum", int'(hum_out), 0);
        check("rst_line_released", int'(dht11 === 1'b1), 1);

        // Direct loads of the result register drive the outputs with no latency.
        force dut.dht11_inst.TempHumi = 16'h1A40;
        #200;
        check("load1_temp", int'(temp_out), 26);
        check("load1_hum", int'(hum_out), 64);
        force dut.dht11_inst.TempHumi = 16'h1237;
        #200;
        check("load2_temp", int'(temp_out), 18);
        check("load2_hum", int'(hum_out), 55);
        force dut.dht11_inst.TempHumi = 16'h1E46;
        #200;
        check("load3_temp", int'(temp_out), 30);
        check("load3_hum", int'(hum_out), 70);
        release dut.dht11_inst.TempHumi;
        repeat (3) @(posedge clk);
        expect_now("reload_rst");

        // Power-up delay then the good frame.
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        frame   = {8'd64, 8'd0, 8'd26, 8'd0, 8'd90};
        sens_on = 1'b1;
        wait_start(T_POWER + 100, "powerup");
        check_range("powerup_delay", last_start - t0, T_POWER - 2, T_POWER + 3);
        run_frame({8'd64, 8'd0, 8'd26, 8'd0, 8'd90}, "good", 1'b0);

        // Bad checksum keeps the previous reading.
        run_frame({8'd55, 8'd0, 8'd18, 8'd0, 8'd0}, "badsum", 1'b1);

        // No sensor: the abort must leave the bus released and the reading untouched.
        sens_on = 1'b0;
        prev_start = last_start;
        wait_start(T_POLL + 100, "nosensor");
        check_range("nosensor_poll_interval", last_start - prev_start, T_POLL - 2, T_POLL + 2);
        k = 0;
        while (host_now && k < T_START + 20) begin
            @(posedge clk);
            k++;
        end
        repeat (60) @(posedge clk);
        check("nosensor_line_released", int'(dht11 === 1'b1), 1);
        expect_now("nosensor");

        // Reset during a bit's high phase.
        frame   = {8'd40, 8'd1, 8'd22, 8'd3, 8'd66};
        sens_on = 1'b1;
        prev_start = last_start;
        wait_start(T_POLL + 100, "rstmid");
        check_range("rstmid_poll_after_timeout", last_start - prev_start, T_POLL - 2, T_POLL + 2);
        k = 0;
        while (!(in_high && bit_idx == 12) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("rstmid_reached_bit", int'(in_high && bit_idx == 12), 1);
        #5;
        rst_n = 1'b0;
        #1;
        model_th = 16'h0000;
        check("rstmid_temp", int'(temp_out), 0);
        check("rstmid_hum", int'(hum_out), 0);
        check("rstmid_line_released", int'(host_now), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        sens_on = 1'b0;
        s0 = start_cnt;
        repeat (T_POWER - 20) @(posedge clk);
        check("rstmid_no_early_start", start_cnt - s0, 0);
        expect_now("rstmid");

        // Randomized frames, roughly half with a corrupted checksum.
        for (int i = 0; i < 3; i++) begin
            h  = 8'($urandom_range(95, 0));
            hd = 8'($urandom_range(9, 0));
            t  = 8'($urandom_range(50, 0));
            td = 8'($urandom_range(9, 0));
            cs = h + hd + t + td;
            if ($urandom_range(1, 0) == 1) cs = cs ^ 8'($urandom_range(255, 1));
            if (i == 0) begin
                frame    = {h, hd, t, td, cs};
                sens_on  = 1'b1;
                wait_start(200, "rand_powerup");
                check_range("rand_powerup_delay", last_start - t0, T_POWER - 2, T_POWER + 3);
                run_frame({h, hd, t, td, cs}, "rand", 1'b0);
            end else begin
                run_frame({h, hd, t, td, cs}, "rand", 1'b1);
            end
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
